// File: rtl/hazard_stall_ctrl_if.sv
// Bundle between the hazard/stall controller and the pipeline datapath.
// The master side drives hazard sources and the slave side returns pipeline controls.
interface hazard_stall_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_is_load;
  logic             ex_pcsel;
  logic             dmem_busy;
  logic             cnt_clr;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             bubble_sel;
  logic             pipe_hold;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_pcsel, dmem_busy, cnt_clr,
    input  pc_write, if_id_write, if_id_flush, bubble_sel, pipe_hold,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_is_load,
           ex_pcsel, dmem_busy, cnt_clr,
    output pc_write, if_id_write, if_id_flush, bubble_sel, pipe_hold,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use / taken-branch hazard controller for the 5-stage RV32 pipe.
// Pipeline enables are combinational so a hazard takes effect in the same cycle it is seen.
module hazard_stall_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input logic                clk,
  input logic                rst,
  hazard_stall_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;

  localparam int unsigned REM_W = 4;

  state_t           state, state_nxt;
  logic [REM_W-1:0] rem, rem_nxt;
  logic             hazard;
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign hazard = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                  ((bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                   (bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Priority: memory busy freezes everything, then flush, then load-use stall.
  always_comb begin
    state_nxt       = state;
    rem_nxt         = rem;
    bus.pc_write    = 1'b1;
    bus.if_id_write = 1'b1;
    bus.if_id_flush = 1'b0;
    bus.bubble_sel  = 1'b0;
    bus.pipe_hold   = 1'b0;
    stall_inc       = 1'b0;
    flush_inc       = 1'b0;
    if (rst) begin
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      bus.if_id_flush = 1'b1;
      bus.bubble_sel  = 1'b1;
    end else if (bus.dmem_busy) begin
      bus.pipe_hold   = 1'b1;
      bus.pc_write    = 1'b0;
      bus.if_id_write = 1'b0;
      stall_inc       = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (bus.ex_pcsel) begin
            // Wrong-path ID instruction: any load-use match is discarded.
            bus.if_id_flush = 1'b1;
            bus.bubble_sel  = 1'b1;
            flush_inc       = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_nxt = FLUSH;
              rem_nxt   = REM_W'(FLUSH_CYCLES - 1);
            end
          end else if (hazard) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.bubble_sel  = 1'b1;
            stall_inc       = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_nxt = LSTALL;
              rem_nxt   = REM_W'(LOAD_BUBBLES - 1);
            end
          end
        end
        LSTALL: begin
          bus.pc_write    = 1'b0;
          bus.if_id_write = 1'b0;
          bus.bubble_sel  = 1'b1;
          stall_inc       = 1'b1;
          rem_nxt         = rem - REM_W'(1);
          if (rem == REM_W'(1)) state_nxt = RUN;
        end
        FLUSH: begin
          bus.if_id_flush = 1'b1;
          bus.bubble_sel  = 1'b1;
          rem_nxt         = rem - REM_W'(1);
          if (rem == REM_W'(1)) state_nxt = RUN;
        end
        default: begin
          state_nxt = RUN;
          rem_nxt   = '0;
        end
      endcase
    end
  end

  // Saturating performance counters; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (bus.cnt_clr) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule
